// File: rtl/log_pe_multibuf.sv
// Logs one datapath value per context step into a pool of log buffers and
// hands committed buffers to the host reader in FIFO order, with occupancy and drop statistics.
module log_pe_multibuf #(
  parameter int CONTEXT_SIZE       = 64,
  parameter int CONTEXT_ADDR_WIDTH = 6,
  parameter int CONTEXT_WIDTH      = 11,
  parameter int LOG_SIZE           = 1024,
  parameter int LOG_ADDR_WIDTH     = 10,
  parameter int NUM_BUFFERS        = 4,
  parameter int DATA_WIDTH         = 32,
  parameter int DROP_CNT_WIDTH     = 16
) (
  input  logic                          CGRA_CLK_I,
  input  logic                          RST_N_I,
  input  logic                          EN_I,
  input  logic                          SYNC_IN_I,
  input  logic                          LOG_TRANSACTIONS_DONE_I,
  input  logic [CONTEXT_ADDR_WIDTH-1:0] CCNT_I,
  input  logic                          CONTEXT_WREN_I,
  input  logic [CONTEXT_ADDR_WIDTH-1:0] CONTEXT_ADDR_I,
  input  logic [CONTEXT_WIDTH-1:0]      CONTEXT_DATA_I,
  input  logic [DATA_WIDTH-1:0]         LOG_DATA_I,
  input  logic [LOG_ADDR_WIDTH-1:0]     LOG_READ_ADDR_I,
  input  logic                          LOG_READ_EN_I,
  input  logic                          STATUS_CLEAR_I,
  output logic [DATA_WIDTH-1:0]         LOG_DATA_O,
  output logic                          LOG_DATA_VALID_O,
  output logic                          LOG_READY_O,
  output logic [2:0]                    LOG_FILL_O,
  output logic                          OVERFLOW_O,
  output logic                          UNDERFLOW_O,
  output logic [DROP_CNT_WIDTH-1:0]     DROP_CNT_O
);

  localparam int PTR_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_BUFFERS - 1);
  localparam logic [2:0]       FULL_FILL = 3'(NUM_BUFFERS - 1);

  logic [CONTEXT_WIDTH-1:0] ctx_mem [CONTEXT_SIZE];
  logic [DATA_WIDTH-1:0]    log_mem [NUM_BUFFERS][LOG_SIZE];

  logic [CONTEXT_WIDTH-1:0]  ctx_q;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [2:0]                fill_q, fill_d;
  logic                      ovf_q, ovf_d;
  logic                      unf_q, unf_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [DROP_CNT_WIDTH-1:0] drop_base;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      valid_q;

  logic full, empty, sync_ok, sync_drop, done_ok, done_bad, clr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Full/empty are judged on the pre-edge fill, so a SYNC at full is dropped
  // even when a DONE frees a buffer in the same cycle.
  always_comb begin
    full      = (fill_q == FULL_FILL);
    empty     = (fill_q == 3'd0);
    sync_ok   = EN_I && SYNC_IN_I && !full;
    sync_drop = EN_I && SYNC_IN_I && full;
    done_ok   = EN_I && LOG_TRANSACTIONS_DONE_I && !empty;
    done_bad  = EN_I && LOG_TRANSACTIONS_DONE_I && empty;
    clr       = EN_I && STATUS_CLEAR_I;

    wr_ptr_d = sync_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = done_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    fill_d = fill_q;
    case ({sync_ok, done_ok})
      2'b10:   fill_d = fill_q + 3'd1;
      2'b01:   fill_d = fill_q - 3'd1;
      default: fill_d = fill_q;
    endcase

    // Clear first, then set, so a same-cycle event survives the clear.
    ovf_d     = (ovf_q && !clr) || sync_drop;
    unf_d     = (unf_q && !clr) || done_bad;
    drop_base = clr ? '0 : drop_q;
    drop_d    = drop_base;
    if (sync_drop && (drop_base != '1)) begin
      drop_d = drop_base + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      ctx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      drop_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= EN_I && LOG_READ_EN_I;
      if (EN_I) begin
        ctx_q    <= ctx_mem[CCNT_I];
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        fill_q   <= fill_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        drop_q   <= drop_d;
        if (LOG_READ_EN_I) begin
          data_q <= log_mem[rd_ptr_q][LOG_READ_ADDR_I];
        end
      end
    end
  end

  always_ff @(posedge CGRA_CLK_I) begin
    if (EN_I && CONTEXT_WREN_I) begin
      ctx_mem[CONTEXT_ADDR_I] <= CONTEXT_DATA_I;
    end
  end

  // Writes use the pre-edge wr_ptr, so data logged alongside SYNC lands in the committing buffer.
  always_ff @(posedge CGRA_CLK_I) begin
    if (EN_I && ctx_q[CONTEXT_WIDTH-1]) begin
      log_mem[wr_ptr_q][ctx_q[LOG_ADDR_WIDTH-1:0]] <= LOG_DATA_I;
    end
  end

  assign LOG_DATA_O       = data_q;
  assign LOG_DATA_VALID_O = valid_q && EN_I;
  assign LOG_READY_O      = (fill_q != 3'd0);
  assign LOG_FILL_O       = fill_q;
  assign OVERFLOW_O       = ovf_q;
  assign UNDERFLOW_O      = unf_q;
  assign DROP_CNT_O       = drop_q;

endmodule

// File: tb/tb_log_pe_multibuf.sv
// Directed bench for log_pe_multibuf: capture, FIFO commit/release, overflow, underflow, reset.
module tb_log_pe_multibuf;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sync_in;
  logic        done;
  logic [5:0]  ccnt;
  logic        ctx_wren;
  logic [5:0]  ctx_addr;
  logic [10:0] ctx_data;
  logic [31:0] log_data;
  logic [9:0]  rd_addr;
  logic        rd_en;
  logic        clr;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_o;
  logic [2:0]  fill_o;
  logic        ovf_o;
  logic        unf_o;
  logic [15:0] drop_o;

  int total = 0;
  int bad   = 0;

  log_pe_multibuf dut (
    .CGRA_CLK_I(clk), .RST_N_I(rst_n), .EN_I(en), .SYNC_IN_I(sync_in),
    .LOG_TRANSACTIONS_DONE_I(done), .CCNT_I(ccnt), .CONTEXT_WREN_I(ctx_wren),
    .CONTEXT_ADDR_I(ctx_addr), .CONTEXT_DATA_I(ctx_data), .LOG_DATA_I(log_data),
    .LOG_READ_ADDR_I(rd_addr), .LOG_READ_EN_I(rd_en), .STATUS_CLEAR_I(clr),
    .LOG_DATA_O(data_o), .LOG_DATA_VALID_O(valid_o), .LOG_READY_O(ready_o),
    .LOG_FILL_O(fill_o), .OVERFLOW_O(ovf_o), .UNDERFLOW_O(unf_o), .DROP_CNT_O(drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctx_write(input logic [5:0] a, input logic [10:0] d);
    ctx_wren = 1'b1; ctx_addr = a; ctx_data = d;
    step();
    ctx_wren = 1'b0;
  endtask

  // Context entry 3 selects address 5: select at one edge, write at the next.
  task automatic log_val(input logic [31:0] v);
    log_data = v; ccnt = 6'd3;
    step();
    ccnt = 6'd0;
    step();
  endtask

  task automatic do_sync();
    sync_in = 1'b1; step(); sync_in = 1'b0;
  endtask

  task automatic do_done();
    done = 1'b1; step(); done = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = 10'd5;
    step();
    rd_en = 1'b0;
    check({tag, "_data"}, 64'(data_o), 64'(exp));
    check({tag, "_valid"}, 64'(valid_o), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; sync_in = 1'b0; done = 1'b0; ccnt = '0;
    ctx_wren = 1'b0; ctx_addr = '0; ctx_data = '0; log_data = '0;
    rd_addr = '0; rd_en = 1'b0; clr = 1'b0;
    #2;
    check("rst_fill", 64'(fill_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_flags", 64'({ovf_o, unf_o, valid_o}), 64'd0);
    check("rst_drop", 64'(drop_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    #10 rst_n = 1'b1;

    ctx_write(6'd0, 11'h000);
    ctx_write(6'd3, 11'h405);

    // Single capture and readback
    log_val(32'hA5);
    do_sync();
    check("t1_fill", 64'(fill_o), 64'd1);
    check("t1_ready", 64'(ready_o), 64'd1);
    do_read("t1_read", 32'hA5);
    step();
    check("t1_valid_drop", 64'(valid_o), 64'd0);
    do_done();
    check("t1_fill_after_done", 64'(fill_o), 64'd0);

    // Three periods, FIFO order
    log_val(32'h11); do_sync();
    log_val(32'h22); do_sync();
    log_val(32'h33); do_sync();
    check("t2_fill3", 64'(fill_o), 64'd3);
    do_read("t2_r11", 32'h11); do_done();
    check("t2_fill2", 64'(fill_o), 64'd2);
    do_read("t2_r22", 32'h22); do_done();
    check("t2_fill1", 64'(fill_o), 64'd1);
    do_read("t2_r33", 32'h33); do_done();
    check("t2_fill0", 64'(fill_o), 64'd0);
    check("t2_ready0", 64'(ready_o), 64'd0);

    // Overflow: dropped period's data is overwritten by the next accepted one
    log_val(32'h51); do_sync();
    log_val(32'h52); do_sync();
    log_val(32'h53); do_sync();
    log_val(32'h44); do_sync();
    check("t3_ovf", 64'(ovf_o), 64'd1);
    check("t3_drop", 64'(drop_o), 64'd1);
    check("t3_fill", 64'(fill_o), 64'd3);
    do_done();
    log_val(32'h66); do_sync();
    check("t3_fill_refill", 64'(fill_o), 64'd3);
    do_read("t3_r52", 32'h52); do_done();
    do_read("t3_r53", 32'h53); do_done();
    do_read("t3_r66", 32'h66); do_done();
    check("t3_fill0", 64'(fill_o), 64'd0);
    clr = 1'b1; step(); clr = 1'b0;
    check("t3_clr_ovf", 64'(ovf_o), 64'd0);
    check("t3_clr_drop", 64'(drop_o), 64'd0);

    // Underflow and clear priority
    do_done();
    check("t4_unf", 64'(unf_o), 64'd1);
    check("t4_fill", 64'(fill_o), 64'd0);
    clr = 1'b1; step(); clr = 1'b0;
    check("t4_unf_clr", 64'(unf_o), 64'd0);
    clr = 1'b1; done = 1'b1; step(); clr = 1'b0; done = 1'b0;
    check("t4_unf_set_wins", 64'(unf_o), 64'd1);
    clr = 1'b1; step(); clr = 1'b0;

    // Simultaneous SYNC+DONE at fill 2, then at fill 3
    log_val(32'h71); do_sync();
    log_val(32'h72); do_sync();
    log_val(32'h73);
    sync_in = 1'b1; done = 1'b1; step(); sync_in = 1'b0; done = 1'b0;
    check("t5_fill2", 64'(fill_o), 64'd2);
    do_read("t5_r72", 32'h72);
    log_val(32'h74); do_sync();
    check("t5_fill3", 64'(fill_o), 64'd3);
    log_val(32'h75);
    sync_in = 1'b1; done = 1'b1; step(); sync_in = 1'b0; done = 1'b0;
    check("t5_fill_full", 64'(fill_o), 64'd2);
    check("t5_drop", 64'(drop_o), 64'd1);
    check("t5_ovf", 64'(ovf_o), 64'd1);
    do_read("t5_r73", 32'h73);
    log_val(32'h76); do_sync();
    do_done();
    do_read("t5_r74", 32'h74);
    do_done();
    do_read("t5_r76", 32'h76);
    do_done();
    check("t5_fill0", 64'(fill_o), 64'd0);

    // Asynchronous reset mid-period
    log_val(32'h81); do_sync();
    log_val(32'h82); do_sync();
    check("t6_fill2", 64'(fill_o), 64'd2);
    do_read("t6_r81", 32'h81);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_fill", 64'(fill_o), 64'd0);
    check("t6_rst_ready", 64'(ready_o), 64'd0);
    check("t6_rst_ovf", 64'(ovf_o), 64'd0);
    check("t6_rst_drop", 64'(drop_o), 64'd0);
    check("t6_rst_data", 64'(data_o), 64'd0);
    check("t6_rst_valid", 64'(valid_o), 64'd0);
    #3 rst_n = 1'b1;
    do_sync();
    check("t6_fill1", 64'(fill_o), 64'd1);

    // Enable low freezes state and suppresses valid
    en = 1'b0; sync_in = 1'b1; rd_en = 1'b1;
    step();
    sync_in = 1'b0; rd_en = 1'b0;
    check("t7_en_fill", 64'(fill_o), 64'd1);
    check("t7_en_valid", 64'(valid_o), 64'd0);
    en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/log_pe_multibuf.md
# log_pe_multibuf

Parametrised successor to the dual-buffer log PE. It captures one CGRA datapath value per context step into an N-deep pool of log buffers. The capture address and write enable come from a per-step context memory indexed by CCNT_I. Committed buffers are handed to the host-side log reader in FIFO order. Unlike the dual-buffer version, it tracks buffer occupancy, refuses to overwrite unread buffers, and reports overflow, underflow and dropped-period statistics.

## Interface
- CONTEXT_SIZE, 64: context memory depth.
- CONTEXT_ADDR_WIDTH, 6: width of CCNT_I and CONTEXT_ADDR_I.
- CONTEXT_WIDTH, 11: context word width. Bit [CONTEXT_WIDTH-1] is the write enable. Bits [LOG_ADDR_WIDTH-1:0] are the log address. Requires CONTEXT_WIDTH-1 >= LOG_ADDR_WIDTH.
- LOG_SIZE, 1024: words per log buffer.
- LOG_ADDR_WIDTH, 10: log address width.
- NUM_BUFFERS, 4: buffers in the pool, 2..8.
- DATA_WIDTH, 32: log word width.
- DROP_CNT_WIDTH, 16: width of the dropped-period counter.

Ports:
- CGRA_CLK_I  in  1  single clock, rising edge.
- RST_N_I  in  1  asynchronous, active-low reset.
- EN_I  in  1  global enable; every state update is gated by it.
- SYNC_IN_I  in  1  end of a logging period; commit request.
- LOG_TRANSACTIONS_DONE_I  in  1  host finished reading the oldest committed buffer; release it.
- CCNT_I  in  CONTEXT_ADDR_WIDTH  context counter.
- CONTEXT_WREN_I  in  1  context write strobe.
- CONTEXT_ADDR_I  in  CONTEXT_ADDR_WIDTH  context write address.
- CONTEXT_DATA_I  in  CONTEXT_WIDTH  context write data.
- LOG_DATA_I  in  DATA_WIDTH  value to log.
- LOG_READ_ADDR_I  in  LOG_ADDR_WIDTH  read address within the oldest committed buffer.
- LOG_READ_EN_I  in  1  read strobe.
- STATUS_CLEAR_I  in  1  clears the sticky flags and the drop counter.
- LOG_DATA_O  out  DATA_WIDTH  registered read data.
- LOG_DATA_VALID_O  out  1  one-cycle pulse qualifying LOG_DATA_O.
- LOG_READY_O  out  1  at least one committed buffer is present.
- LOG_FILL_O  out  3  number of committed buffers, 0..NUM_BUFFERS-1.
- OVERFLOW_O  out  1  sticky: a SYNC was dropped.
- UNDERFLOW_O  out  1  sticky: a DONE arrived with nothing committed.
- DROP_CNT_O  out  DROP_CNT_WIDTH  number of dropped periods, saturating.

## Operation
- State:
  - wr_ptr, the buffer currently being filled.
  - rd_ptr, the oldest committed buffer.
  - fill, the committed count.
  - Both pointers wrap modulo NUM_BUFFERS.
  - The write buffer is never counted in fill, so full means fill == NUM_BUFFERS-1.
- Context memory:
  - Written when EN_I && CONTEXT_WREN_I.
  - ctx_q <= mem[CCNT_I] every enabled cycle.
- Log write: when EN_I and ctx_q MSB = 1, buf[wr_ptr][ctx_q[LOG_ADDR_WIDTH-1:0]] <= LOG_DATA_I.
- SYNC_IN_I:
  - If not full: wr_ptr <= wr_ptr+1 and fill <= fill+1.
  - If full: pointers and fill are unchanged, OVERFLOW_O <= 1, and DROP_CNT_O increments, saturating at all-ones. The period's data stays in the write buffer and is overwritten by the next period.
- LOG_TRANSACTIONS_DONE_I:
  - If fill > 0: rd_ptr <= rd_ptr+1 and fill <= fill-1.
  - If fill == 0: ignored, and UNDERFLOW_O <= 1.
- SYNC and DONE in the same cycle:
  - Evaluate full and empty on the pre-edge fill.
  - Full with a valid DONE: the DONE releases a buffer, and the SYNC is still dropped, because the full check uses the pre-edge fill.
  - Otherwise both apply, and fill is unchanged when both are accepted.
- Read:
  - On LOG_READ_EN_I, LOG_DATA_O <= buf[rd_ptr][LOG_READ_ADDR_I] and LOG_DATA_VALID_O is pulsed.
  - When fill == 0, the read still occurs and returns stale contents; LOG_READY_O = 0 flags this.
- STATUS_CLEAR_I clears OVERFLOW_O, UNDERFLOW_O and DROP_CNT_O. If the same cycle also sets a flag, the set wins.
- Reset:
  - wr_ptr = 0, rd_ptr = 0, fill = 0, ctx_q = 0.
  - All outputs are 0.
  - Memory contents are not reset.
  - Reset mid-period discards all pending buffers.

## Timing
- Context read latency: 1 cycle. The context word selected by CCNT_I at edge k gates the LOG_DATA_I write at edge k+1.
- A log write in the same cycle as SYNC lands in the old wr_ptr buffer. The new buffer starts at the next edge.
- Read latency: 1 cycle. LOG_DATA_O is valid from LOG_READ_EN_I at edge k until the next enabled read.
- A read in the same cycle as DONE uses the old rd_ptr.
- LOG_READY_O, LOG_FILL_O and the flags update at the same edge as the triggering event.
- EN_I = 0 freezes all state. LOG_DATA_VALID_O is 0 while EN_I = 0.

## Test plan
- Reset, then program context entry 3 = {1, addr 5}. Drive CCNT_I = 3 with LOG_DATA_I = 0xA5 and send one SYNC. Expected: LOG_FILL_O = 1, LOG_READY_O = 1, and a read of address 5 returns 0xA5 one cycle later with LOG_DATA_VALID_O pulsed.
- NUM_BUFFERS = 4, three periods logging 0x11, 0x22, 0x33 followed by SYNCs, then three DONEs interleaved with reads. Expected: reads return 0x11, 0x22, 0x33 in order, and fill goes 3 → 0.
- Fill to 3, log 0x44, then SYNC. Expected: OVERFLOW_O = 1, DROP_CNT_O = 1, fill stays 3, and the next accepted period's data overwrites 0x44.
- DONE with fill = 0. Expected: UNDERFLOW_O = 1 and fill stays 0. STATUS_CLEAR_I then clears the flag. With DONE and STATUS_CLEAR_I in the same cycle at fill = 0, the flag stays 1.
- Simultaneous SYNC and DONE at fill = 2. Expected: fill stays 2 and both pointers advance. At fill = 3: fill becomes 2, the drop counter increments, and wr_ptr holds.
- Assert RST_N_I low mid-period with fill = 2, asynchronously between edges. Expected: all outputs 0 immediately, with no clock edge needed, and the first SYNC after reset yields fill = 1.
